ireg_file: RTL and testbench

Parametrised integer register file for the OSECPU core. Configurable word width, depth and read-port count, with one write port. Contents are zeroed by a hardware clear sequencer after reset or on request, with a busy indication. Sits between decode (read addresses) and writeback (write port), replacing the fixed 64x32, 2-read register file.

---
 rtl/osecpu_pkg.sv | 21 ++
 rtl/ireg_clr_seq.sv | 68 ++++++
 rtl/ireg_file.sv | 91 +++++++++
 tb/tb_ireg_file.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/osecpu_pkg.sv
// osecpu_pkg: shared definitions for the OSECPU integer register file.
//
//   IREG_WIDTH   default data word width of the integer register file
//   IREG_ADDR_W  default address width (depth = 2**IREG_ADDR_W)
//   ireg_state_e clear-sequencer state encoding (ST_CLEAR = 0, ST_IDLE = 1)
//   ireg_depth() number of entries addressed by an address of a given width
package osecpu_pkg;

  localparam int IREG_WIDTH  = 32;
  localparam int IREG_ADDR_W = 6;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } ireg_state_e;

  function automatic int ireg_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ireg_clr_seq.sv
// ireg_clr_seq: hardware clear sequencer for the integer register file.
//
// Walks every entry of the register file once, issuing a zero-write per
// cycle, after reset and whenever a clear is requested while idle.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset; forces a fresh clear sequence
//   clr_req   request a full clear; only honoured while idle
//   busy      high while the clear sequence runs (registered)
//   clr_we    clear write enable toward the storage array
//   clr_addr  entry being zeroed this cycle
module ireg_clr_seq
  import osecpu_pkg::*;
#(
  parameter int ADDR_W = IREG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  ireg_state_e       state;
  logic [ADDR_W-1:0] clr_cnt;

  // Single-block FSM; busy is registered so it is glitch-free for callers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST) begin
            // Last entry is zeroed at this edge; hand control back.
            state   <= ST_IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_cnt <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/ireg_file.sv
// ireg_file: parametrised integer register file for the OSECPU core.
//
// DEPTH = 2**ADDR_W words of WIDTH bits, one synchronous write port and
// NREAD (1..4) combinational read ports. Contents are zeroed by the clear
// sequencer after reset or on clr_req; all read ports return 0 while busy.
//
// Build option: define IREG_BYPASS_EN to forward write data to any read
// port addressing the entry being written in the same cycle. Without it a
// read returns the old contents until the write edge.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   clr_req  request full clear (sampled only while idle)
//   busy     high while the clear sequence runs
//   ra       packed read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd       packed read data,      port i = rd[i*WIDTH +: WIDTH]
//   we       write enable (ignored while busy)
//   wa       write address
//   wd       write data
module ireg_file
  import osecpu_pkg::*;
#(
  parameter int WIDTH  = IREG_WIDTH,
  parameter int ADDR_W = IREG_ADDR_W,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*WIDTH-1:0]  rd,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [WIDTH-1:0]        wd
);

  localparam int DEPTH = ireg_depth(ADDR_W);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [WIDTH-1:0]  mem [DEPTH];

  ireg_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Storage has no reset of its own. Any write pending while reset is high
  // is abandoned; the sequencer write wins over the user port, so a user
  // write during a clear is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (we) begin
        mem[wa] <= wd;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    logic [WIDTH-1:0]  port_data;

    assign port_addr = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      port_data = mem[port_addr];
`ifdef IREG_BYPASS_EN
      if (we && (port_addr == wa)) begin
        port_data = wd;
      end
`endif
      // Reads while clearing show the final cleared value.
      if (busy) begin
        port_data = '0;
      end
    end

    assign rd[i*WIDTH +: WIDTH] = port_data;
  end

endmodule

// File: tb/tb_ireg_file.sv
module tb_ireg_file;

`ifdef IREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance: 64 x 32, 2 read ports
  logic        reset, clr_req, busy, we;
  logic [5:0]  ra0, ra1, wa;
  logic [11:0] ra;
  logic [63:0] rd;
  logic [31:0] wd, rd0, rd1;
  assign ra  = {ra1, ra0};
  assign rd0 = rd[31:0];
  assign rd1 = rd[63:32];

  // Small instance: 8 x 16, 4 read ports
  logic        s_reset, s_clr_req, s_busy, s_we;
  logic [2:0]  s_ra [4];
  logic [11:0] s_ra_bus;
  logic [63:0] s_rd;
  logic [2:0]  s_wa;
  logic [15:0] s_wd;
  assign s_ra_bus = {s_ra[3], s_ra[2], s_ra[1], s_ra[0]};

  ireg_file #(.WIDTH(32), .ADDR_W(6), .NREAD(2)) u_dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy),
    .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd)
  );

  ireg_file #(.WIDTH(16), .ADDR_W(3), .NREAD(4)) u_small (
    .clk(clk), .reset(s_reset), .clr_req(s_clr_req), .busy(s_busy),
    .ra(s_ra_bus), .rd(s_rd), .we(s_we), .wa(s_wa), .wd(s_wd)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model   [64];
  logic [15:0] s_model [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge. Counts cycles with busy high; optionally pulses
  // clr_req for one cycle at count pulse_at.
  task automatic meas_busy(input int pulse_at, output int n, output bit rd_zero);
    n = 0;
    rd_zero = 1'b1;
    while (busy === 1'b1 && n < 500) begin
      clr_req = (n == pulse_at);
      #1;
      if (rd !== 64'd0) rd_zero = 1'b0;
      n++;
      @(negedge clk);
    end
    clr_req = 1'b0;
  endtask

  // Called at a negedge while idle; one write per cycle.
  task automatic wr(input int a, input logic [31:0] d);
    we = 1'b1; wa = 6'(a); wd = d;
    @(negedge clk);
    we = 1'b0;
    model[a] = d;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 64; a += 2) begin
      ra0 = 6'(a); ra1 = 6'(a + 1);
      #1;
      check($sformatf("%s_rd%0d", tag, a), rd0, model[a]);
      check($sformatf("%s_rd%0d", tag, a + 1), rd1, model[a + 1]);
      @(negedge clk);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < 64; a++) model[a] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    bit          z;
    logic [31:0] e0, e1;

    clear_model();
    for (int a = 0; a < 8; a++) s_model[a] = 16'd0;
    reset = 1'b1; clr_req = 1'b0;
    we = 1'b1; wa = 6'd10; wd = 32'hDEADBEEF; ra0 = 6'd10; ra1 = 6'd0;
    s_reset = 1'b1; s_clr_req = 1'b0; s_we = 1'b0; s_wa = '0; s_wd = '0;
    for (int k = 0; k < 4; k++) s_ra[k] = '0;

    // Reset held 3 cycles with a write pending; then the initial clear
    repeat (3) @(negedge clk);
    #1;
    check("busy_in_reset", 32'(busy), 32'd1);
    check("rd0_in_reset", rd0, 32'd0);
    check("rd1_in_reset", rd1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    meas_busy(-1, n, z);
    we = 1'b0;
    check("init_clear_len", 32'(n), 32'd64);
    check("rd_zero_while_busy", 32'(z), 32'd1);
    #1;
    check("busy_after_clear", 32'(busy), 32'd0);
    check("dropped_write_10", rd0, 32'd0);
    @(negedge clk);
    read_all("init");

    // Simple write, read on both ports, neighbour untouched
    wr(5, 32'h3);
    ra0 = 6'd5; ra1 = 6'd5;
    #1;
    check("wr5_port0", rd0, 32'h3);
    check("wr5_port1", rd1, 32'h3);
    ra0 = 6'd6;
    #1;
    check("addr6_zero", rd0, 32'd0);
    @(negedge clk);

    // Fill all entries, then clear on request with a second request mid-clear
    for (int a = 0; a < 64; a++) wr(a, 32'(a + 1));
    read_all("fill");
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    #1;
    check("busy_after_req", 32'(busy), 32'd1);
    meas_busy(20, n, z);
    check("req_clear_len", 32'(n), 32'd64);
    check("req_rd_zero_busy", 32'(z), 32'd1);
    clear_model();
    read_all("reqclr");

    // Randomised traffic against the array model
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = 6'($urandom_range(0, 63));
      wd = $urandom;
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      #1;
      e0 = (we && ra0 == wa && BYP) ? wd : model[ra0];
      e1 = (we && ra1 == wa && BYP) ? wd : model[ra1];
      check("rand_rd0", rd0, e0);
      check("rand_rd1", rd1, e1);
      @(negedge clk);
      if (we) model[wa] = wd;
    end
    we = 1'b0;

    // Read/write collision
    wr(7, 32'd1);
    we = 1'b1; wa = 6'd7; wd = 32'd2; ra0 = 6'd7;
    #1;
    check("collide_same_cycle", rd0, BYP ? 32'd2 : 32'd1);
    @(negedge clk);
    we = 1'b0;
    model[7] = 32'd2;
    #1;
    check("collide_next_cycle", rd0, 32'd2);
    @(negedge clk);

    // Reset in the middle of a clear restarts a full clear
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    we = 1'b1; wa = 6'd3; wd = 32'h55;
    #1;
    check("busy_mid_reset", 32'(busy), 32'd1);
    check("rd_mid_reset", rd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    meas_busy(-1, n, z);
    we = 1'b0;
    check("restart_clear_len", 32'(n), 32'd64);
    check("restart_rd_zero", 32'(z), 32'd1);
    clear_model();
    @(negedge clk);
    read_all("restart");

    // Small configuration: 8-entry clear, 4 read ports
    s_reset = 1'b0;
    n = 0;
    while (s_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("small_init_len", 32'(n), 32'd8);
    for (int a = 0; a < 8; a++) begin
      s_we = 1'b1; s_wa = 3'(a); s_wd = 16'($urandom);
      @(negedge clk);
      s_model[a] = s_wd;
    end
    s_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) s_ra[k] = 3'($urandom_range(0, 7));
      s_ra[3] = s_ra[0];
      #1;
      for (int k = 0; k < 4; k++)
        check($sformatf("small_rd%0d", k), 32'(s_rd[k*16 +: 16]), 32'(s_model[s_ra[k]]));
      @(negedge clk);
    end
    s_clr_req = 1'b1;
    @(negedge clk);
    s_clr_req = 1'b0;
    repeat (3) @(negedge clk);
    s_reset = 1'b1;
    #1;
    check("small_busy_reset", 32'(s_busy), 32'd1);
    check("small_rd_reset", 32'(s_rd[15:0]), 32'd0);
    @(negedge clk);
    s_reset = 1'b0;
    n = 0;
    while (s_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("small_restart_len", 32'(n), 32'd8);
    for (int a = 0; a < 8; a += 4) begin
      for (int k = 0; k < 4; k++) s_ra[k] = 3'(a + k);
      #1;
      for (int k = 0; k < 4; k++)
        check($sformatf("small_clr%0d", a + k), 32'(s_rd[k*16 +: 16]), 32'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
